sopc_anemometre_btn_debounce: RTL and testbench

SOPC_ANEMOMETRE_BTN_DEBOUNCE -- requirements
Module: sopc_anemometre_btn_debounce

---
 rtl/sopc_anemometre_btn_debounce.sv | 107 ++++++++++
 tb/tb_sopc_anemometre_btn_debounce.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sopc_anemometre_btn_debounce.sv
// -----------------------------------------------------------------------------
// sopc_anemometre_btn_debounce
//
// Push-button conditioner for the anemometer SOPC. Each key pin is
// synchronised into the clk domain, polarity-corrected so that 1 always means
// "pressed", and then debounced. A new level is accepted only after it has
// been seen unchanged for DEBOUNCE_CYCLES consecutive clock cycles. The
// debounced level drives the BOUTONS PIO. An optional one-cycle press pulse is
// also available.
//
// Parameters
//   N_BTN            number of push-button channels
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level
//                    (1 .. 2^20; default 1 ms at 50 MHz)
//   ACTIVE_LOW       1: a pressed key reads 0 on btn_raw (inverted at entry)
//
// Ports
//   clk        in   system clock (single clock domain)
//   reset      in   synchronous, active-high reset
//   btn_raw    in   [N_BTN] asynchronous, bouncing key pins
//   btn_clean  out  [N_BTN] debounced level, 1 = pressed (registered)
//   btn_press  out  [N_BTN] one-cycle pulse per accepted press
//
// Build option
//   BTN_PRESS_PULSE_EN  when defined, btn_press pulses for one cycle after each
//                       accepted 0->1 transition of btn_clean. When undefined,
//                       btn_press is tied to 0 and no edge-detect register
//                       exists; btn_clean is unaffected.
// -----------------------------------------------------------------------------
module sopc_anemometre_btn_debounce #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_clean,
    output logic [N_BTN-1:0] btn_press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_BTN-1:0] POL_MASK = {N_BTN{ACTIVE_LOW}};

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] stable_q;
    logic [N_BTN-1:0] stable_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];

    // Per-channel debounce decision. The counter measures how long sync2 has
    // disagreed with the accepted level; any agreement clears it, so a bounce
    // restarts the count. Acceptance reloads the counter with 0 on the same
    // edge, which keeps it within 0..DEBOUNCE_CYCLES-1 and prevents wrapping.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '{default: '0};
        for (int i = 0; i < N_BTN; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Polarity is corrected before the first flop, so the reset value 0 of the
    // synchronisers always means "released" whatever ACTIVE_LOW is.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '{default: '0};
        end else begin
            sync1_q  <= btn_raw ^ POL_MASK;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign btn_clean = stable_q;

`ifdef BTN_PRESS_PULSE_EN
    logic [N_BTN-1:0] press_q;

    // Registered on the same edge that stable rises, so the pulse occupies
    // exactly the cycle following acceptance. Releases produce nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_q <= '0;
        end else begin
            press_q <= stable_d & ~stable_q;
        end
    end

    assign btn_press = press_q;
`else
    assign btn_press = '0;
`endif

endmodule

// File: tb/tb_sopc_anemometre_btn_debounce.sv
// Directed bench for sopc_anemometre_btn_debounce with DEBOUNCE_CYCLES=8,
// ACTIVE_LOW=1. Expected press pulses are masked to zero when the press
// pulse option is not compiled in.
module tb_sopc_anemometre_btn_debounce;

    localparam int N = 2;
    localparam int D = 8;

`ifdef BTN_PRESS_PULSE_EN
    localparam logic [N-1:0] PMASK = 2'b11;
`else
    localparam logic [N-1:0] PMASK = 2'b00;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_clean;
    logic [N-1:0] btn_press;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         rst;
        logic [N-1:0] raw;
        logic [N-1:0] clean;
        logic [N-1:0] press;
    } vec_t;

    vec_t tbl[$];

    sopc_anemometre_btn_debounce #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn_clean(btn_clean),
        .btn_press(btn_press)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic r, input logic [N-1:0] raw,
                                input logic [N-1:0] cl, input logic [N-1:0] pr);
        vec_t v;
        v.rst = r; v.raw = raw; v.clean = cl; v.press = pr;
        tbl.push_back(v);
    endfunction

    // Apply inputs, let one rising edge pass, then compare 1 ns later.
    task automatic step(input logic r, input logic [N-1:0] raw,
                        input logic [N-1:0] exp_clean, input logic [N-1:0] exp_press,
                        input string name);
        logic [N-1:0] ep;
        reset   = r;
        btn_raw = raw;
        @(posedge clk);
        #1;
        ep = exp_press & PMASK;
        checks++;
        if (btn_clean !== exp_clean || btn_press !== ep) begin
            errors++;
            $display("FAIL %s t=%0t: clean=%b press=%b, required clean=%b press=%b",
                     name, $time, btn_clean, btn_press, exp_clean, ep);
        end
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 2'b11;

        // Reset, then key 0 pressed and held, then released.
        add(1, 2'b11, 2'b00, 2'b00);
        add(1, 2'b11, 2'b00, 2'b00);
        add(0, 2'b11, 2'b00, 2'b00);
        for (int s = 0; s < 9; s++) add(0, 2'b10, 2'b00, 2'b00);
        add(0, 2'b10, 2'b01, 2'b01);
        for (int s = 0; s < 3; s++) add(0, 2'b10, 2'b01, 2'b00);
        for (int s = 0; s < 9; s++) add(0, 2'b11, 2'b01, 2'b00);
        for (int s = 0; s < 3; s++) add(0, 2'b11, 2'b00, 2'b00);

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].rst, tbl[i].raw, tbl[i].clean, tbl[i].press, "tbl_press_release");

        // Key 1 bouncing with period 6: never stable long enough.
        for (int c = 0; c < 60; c++)
            step(0, ((c / 3) % 2 == 0) ? 2'b01 : 2'b11, 2'b00, 2'b00, "bounce_key1");
        for (int c = 0; c < 4; c++) step(0, 2'b11, 2'b00, 2'b00, "bounce_settle");

        // Hold 7, release 1, hold again: accept 9 edges after second hold.
        for (int s = 0; s < 7; s++) step(0, 2'b10, 2'b00, 2'b00, "short_hold");
        step(0, 2'b11, 2'b00, 2'b00, "short_gap");
        for (int s = 8; s < 17; s++) step(0, 2'b10, 2'b00, 2'b00, "rehold_wait");
        step(0, 2'b10, 2'b01, 2'b01, "rehold_accept");
        step(0, 2'b10, 2'b01, 2'b00, "rehold_pulse_end");
        for (int s = 0; s < 9; s++) step(0, 2'b11, 2'b01, 2'b00, "rehold_release_wait");
        step(0, 2'b11, 2'b00, 2'b00, "rehold_released");
        step(0, 2'b11, 2'b00, 2'b00, "rehold_idle");

        // Both keys pressed on the same edge, then both released.
        for (int s = 0; s < 9; s++) step(0, 2'b00, 2'b00, 2'b00, "both_wait");
        step(0, 2'b00, 2'b11, 2'b11, "both_accept");
        step(0, 2'b00, 2'b11, 2'b00, "both_pulse_end");
        for (int s = 0; s < 8; s++) step(0, 2'b11, 2'b11, 2'b00, "both_release_wait");
        step(0, 2'b11, 2'b11, 2'b00, "both_release_wait");
        step(0, 2'b11, 2'b00, 2'b00, "both_released");
        step(0, 2'b11, 2'b00, 2'b00, "both_idle");

        // Reset in the middle of a count with the key held.
        for (int s = 0; s < 7; s++) step(0, 2'b10, 2'b00, 2'b00, "midcount_press");
        step(1, 2'b10, 2'b00, 2'b00, "midcount_in_reset");
        step(1, 2'b10, 2'b00, 2'b00, "midcount_in_reset");
        for (int s = 0; s < 9; s++) step(0, 2'b10, 2'b00, 2'b00, "after_reset_wait");
        step(0, 2'b10, 2'b01, 2'b01, "after_reset_accept");
        for (int s = 0; s < 3; s++) step(0, 2'b10, 2'b01, 2'b00, "after_reset_single_pulse");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
